// File: rtl/omap_biu_packer.sv
// Output-map bus interface: selects one byte field per merged beat, packs DW/8 bytes
// per bus word and issues address-incrementing writes; pulses layer_done per layer.
module omap_biu_packer #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [AW-1:0]     cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_pix_num,
  input  logic [1:0]        cfg_sel,
  input  logic [31:0]       map_merger2omap_biu_data,
  input  logic              map_merger2omap_biu_vld,
  output logic              map_merger2omap_biu_rdy,
  output logic [AW-1:0]     omap_wr_addr,
  output logic [DW-1:0]     omap_wr_data,
  output logic [DW/8-1:0]   omap_wr_strb,
  output logic              omap_wr_vld,
  input  logic              omap_wr_rdy,
  output logic              layer_done
);

  localparam int PACK_N = DW / 8;
  localparam int IW     = $clog2(PACK_N);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  pix_num_r, pix_cnt;
  logic [1:0]        sel_r;
  logic [IW-1:0]     byte_idx;
  logic [AW-1:0]     word_addr;
  logic [DW-1:0]     pack;
  logic [7:0]        sel_byte;
  logic [DW-1:0]     word_nxt;
  logic [PACK_N-1:0] strb_nxt;
  logic              last_pix, completes, accept, drain;
  logic              unused_bits;

  assign unused_bits = ^map_merger2omap_biu_data[31:24];

  assign last_pix  = (pix_cnt == pix_num_r - CNT_W'(1));
  assign completes = (byte_idx == IW'(PACK_N - 1)) || last_pix;
  assign drain     = omap_wr_vld & omap_wr_rdy;
  assign accept    = map_merger2omap_biu_vld & map_merger2omap_biu_rdy;

  always_comb begin
    case (sel_r)
      2'd0:    sel_byte = map_merger2omap_biu_data[23:16];
      2'd1:    sel_byte = map_merger2omap_biu_data[15:8];
      2'd2:    sel_byte = map_merger2omap_biu_data[7:0];
      default: sel_byte = 8'h00;
    endcase
  end

  // Word image for a completing beat: earlier packed bytes, the new byte, zeros above.
  always_comb begin
    word_nxt = '0;
    strb_nxt = '0;
    for (int k = 0; k < PACK_N; k++) begin
      if (IW'(k) < byte_idx)       word_nxt[8*k +: 8] = pack[8*k +: 8];
      else if (IW'(k) == byte_idx) word_nxt[8*k +: 8] = sel_byte;
      strb_nxt[k] = (IW'(k) <= byte_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = (cfg_pix_num == '0) ? DONE : RUN;
      RUN:     if (accept && last_pix) state_nxt = DRAIN;
      DRAIN:   if (!omap_wr_vld || omap_wr_rdy) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A completing beat may only stall when the output register is full and not draining.
  always_comb begin
    map_merger2omap_biu_rdy = (state == RUN) && (!completes || !omap_wr_vld || omap_wr_rdy);
    layer_done              = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt      <= '0;
      byte_idx     <= '0;
      word_addr    <= '0;
      omap_wr_vld  <= 1'b0;
      omap_wr_addr <= '0;
      omap_wr_data <= '0;
      omap_wr_strb <= '0;
    end else begin
      if (state == IDLE && cfg_start) begin
        pix_num_r <= cfg_pix_num;
        sel_r     <= cfg_sel;
        word_addr <= cfg_base_addr;
        pix_cnt   <= '0;
        byte_idx  <= '0;
      end
      if (drain) omap_wr_vld <= 1'b0;
      if (accept) begin
        pix_cnt                    <= pix_cnt + CNT_W'(1);
        pack[{byte_idx, 3'b000} +: 8] <= sel_byte;
        if (completes) begin
          byte_idx     <= '0;
          word_addr    <= word_addr + AW'(PACK_N);
          omap_wr_addr <= word_addr;
          omap_wr_data <= word_nxt;
          omap_wr_strb <= strb_nxt;
          omap_wr_vld  <= 1'b1;
        end else begin
          byte_idx <= byte_idx + IW'(1);
        end
      end
    end
  end

endmodule
